crossing_arbiter: RTL and testbench

Arbitrates pedestrian-crossing buttons and emergency-vehicle preemption requests for the two-road traffic light, and drives the light controller's hold/force inputs. It sits between the debounced board inputs and the traffic-light state/countdown controller, and observes the controller's current phase. It decides when a walk interval is granted, and it freezes the controller's countdown while a walk is in progress. It forces a green phase for an emergency vehicle while keeping fairness between the two roads.

---
 rtl/crossing_arbiter.sv | 160 ++++++++++++++++
 tb/tb_crossing_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/crossing_arbiter.sv
// Pedestrian-walk and emergency-preemption arbiter sitting between the debounced
// board inputs and the traffic-light controller's hold/force inputs.
module crossing_arbiter #(
    parameter int WALK_LEN = 5,
    parameter int EMG_MAX  = 15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic [2:0] phase_i,
    input  logic [1:0] ped_req_i,
    input  logic [1:0] emg_req_i,
    output logic       hold_o,
    output logic       force_o,
    output logic [2:0] force_phase_o,
    output logic [1:0] walk_o,
    output logic [1:0] wait_o,
    output logic       busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WALK = 2'd1;
    localparam logic [1:0] S_EMG  = 2'd2;
    localparam logic [1:0] S_LOCK = 2'd3;

    localparam logic [3:0] WALK_LIM = 4'(WALK_LEN);
    localparam logic [3:0] EMG_LIM  = 4'(EMG_MAX);

    logic [1:0] pedMeta_q, pedSync_q, pedPrev_q;
    logic [1:0] emgMeta_q, emgSync_q;
    logic [1:0] pedRise;

    logic [1:0] state_q, state_d;
    logic       road_q, road_d;
    logic       rr_q, rr_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [1:0] pending_q, pending_d;

    logic [3:0] wcntInc;
    logic [3:0] entryCnt;
    logic       emgWin;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pedMeta_q <= 2'b00;
            pedSync_q <= 2'b00;
            pedPrev_q <= 2'b00;
            emgMeta_q <= 2'b00;
            emgSync_q <= 2'b00;
        end else begin
            pedMeta_q <= ped_req_i;
            pedSync_q <= pedMeta_q;
            pedPrev_q <= pedSync_q;
            emgMeta_q <= emg_req_i;
            emgSync_q <= emgMeta_q;
        end
    end

    assign pedRise  = pedSync_q & ~pedPrev_q;
    assign wcntInc  = tick_i ? ((wcnt_q == 4'hF) ? 4'hF : wcnt_q + 4'd1) : wcnt_q;
    assign entryCnt = tick_i ? 4'd1 : 4'd0;
    // On a simultaneous request the road that was not served last time wins.
    assign emgWin   = emgSync_q[1] & (~emgSync_q[0] | ~rr_q);

    always_comb begin
        state_d   = state_q;
        road_d    = road_q;
        rr_d      = rr_q;
        wcnt_d    = wcnt_q;
        pending_d = pending_q | pedRise;
        case (state_q)
            S_IDLE: begin
                wcnt_d = 4'd0;
                if (|emgSync_q) begin
                    state_d = S_EMG;
                    road_d  = emgWin;
                    rr_d    = emgWin;
                    wcnt_d  = entryCnt;
                end else if (pending_q[1] && phase_i == 3'd0) begin
                    state_d = S_WALK;
                    road_d  = 1'b1;
                    wcnt_d  = entryCnt;
                end else if (pending_q[0] && phase_i == 3'd3) begin
                    state_d = S_WALK;
                    road_d  = 1'b0;
                    wcnt_d  = entryCnt;
                end
            end
            S_WALK: begin
                if (|emgSync_q) begin
                    state_d = S_EMG;
                    road_d  = emgWin;
                    rr_d    = emgWin;
                    wcnt_d  = entryCnt;
                end else if (wcntInc >= WALK_LIM) begin
                    state_d           = S_IDLE;
                    pending_d[road_q] = 1'b0;
                    wcnt_d            = 4'd0;
                end else begin
                    wcnt_d = wcntInc;
                end
            end
            S_EMG: begin
                if (!emgSync_q[road_q]) begin
                    state_d = S_IDLE;
                    wcnt_d  = 4'd0;
                end else if (wcntInc >= EMG_LIM) begin
                    state_d = S_LOCK;
                    wcnt_d  = 4'd0;
                end else begin
                    wcnt_d = wcntInc;
                end
            end
            S_LOCK: begin
                if (emgSync_q[~road_q]) begin
                    state_d = S_EMG;
                    road_d  = ~road_q;
                    rr_d    = ~road_q;
                    wcnt_d  = entryCnt;
                end else if (!emgSync_q[road_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                wcnt_d  = 4'd0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they change with the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            road_q        <= 1'b0;
            rr_q          <= 1'b1;
            wcnt_q        <= 4'd0;
            pending_q     <= 2'b00;
            hold_o        <= 1'b0;
            force_o       <= 1'b0;
            force_phase_o <= 3'd0;
            walk_o        <= 2'b00;
            busy_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            road_q        <= road_d;
            rr_q          <= rr_d;
            wcnt_q        <= wcnt_d;
            pending_q     <= pending_d;
            hold_o        <= (state_d == S_WALK) || (state_d == S_EMG);
            force_o       <= (state_d == S_EMG);
            force_phase_o <= (state_d == S_EMG && road_d) ? 3'd3 : 3'd0;
            walk_o        <= (state_d == S_WALK) ? (road_d ? 2'b10 : 2'b01) : 2'b00;
            busy_o        <= (state_d != S_IDLE);
        end
    end

    assign wait_o = pending_q;

endmodule

// File: tb/tb_crossing_arbiter.sv
// Directed-plus-randomized bench for crossing_arbiter with an arithmetic reference
// for walk/preemption lengths and a round-robin model for emergency arbitration.
module tb_crossing_arbiter;

    localparam int WALK_LEN = 5;
    localparam int EMG_MAX  = 15;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [2:0] phase;
    logic [1:0] ped;
    logic [1:0] emg;
    logic       hold;
    logic       forceOut;
    logic [2:0] forcePhase;
    logic [1:0] walk;
    logic [1:0] waitOut;
    logic       busy;

    int checks = 0;
    int errors = 0;

    crossing_arbiter #(.WALK_LEN(WALK_LEN), .EMG_MAX(EMG_MAX)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tick_i       (tick),
        .phase_i      (phase),
        .ped_req_i    (ped),
        .emg_req_i    (emg),
        .hold_o       (hold),
        .force_o      (forceOut),
        .force_phase_o(forcePhase),
        .walk_o       (walk),
        .wait_o       (waitOut),
        .busy_o       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] pedV, input logic [1:0] emgV, input logic [2:0] phaseV);
        ped   = pedV;
        emg   = emgV;
        phase = phaseV;
    endtask

    task automatic stepClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Idle gap first so a tick never lands on the cycle a state is entered.
    task automatic pulseTick();
        stepClk($urandom_range(1, 4));
        tick = 1'b1;
        stepClk(1);
        tick = 1'b0;
    endtask

    task automatic runWalk(input logic [1:0] walkBits, input logic [1:0] waitBits);
        for (int i = 1; i <= WALK_LEN; i++) begin
            pulseTick();
            checkOutput($sformatf("walk_tick%0d", i), 8'(walk), (i < WALK_LEN) ? 8'(walkBits) : 8'h00);
            checkOutput($sformatf("wait_tick%0d", i), 8'(waitOut), (i < WALK_LEN) ? 8'(waitBits) : 8'h00);
        end
        checkOutput("walk_done_busy", 8'(busy), 8'h00);
        checkOutput("walk_done_hold", 8'(hold), 8'h00);
    endtask

    initial begin
        logic [2:0] noServe;
        logic [1:0] pattern;
        logic       rrModel;
        logic       winner;
        logic       expForce;

        tick  = 1'b0;
        rst_n = 1'b0;
        applyStimulus(2'b00, 2'b00, 3'd0);
        stepClk(3);
        checkOutput("rst_hold", 8'(hold), 8'h00);
        checkOutput("rst_force", 8'(forceOut), 8'h00);
        checkOutput("rst_fphase", 8'(forcePhase), 8'h00);
        checkOutput("rst_walk", 8'(walk), 8'h00);
        checkOutput("rst_wait", 8'(waitOut), 8'h00);
        checkOutput("rst_busy", 8'(busy), 8'h00);
        #2 rst_n = 1'b1;
        stepClk(2);

        $display("[TB] road-1 walk in GR");
        applyStimulus(2'b10, 2'b00, 3'd0);
        stepClk(2);
        checkOutput("ped1_wait_early", 8'(waitOut), 8'h00);
        stepClk(1);
        checkOutput("ped1_wait_3clk", 8'(waitOut), 8'h02);
        checkOutput("ped1_walk_not_yet", 8'(walk), 8'h00);
        stepClk(1);
        checkOutput("ped1_walk_on", 8'(walk), 8'h02);
        checkOutput("ped1_hold_on", 8'(hold), 8'h01);
        checkOutput("ped1_busy_on", 8'(busy), 8'h01);
        checkOutput("ped1_force_off", 8'(forceOut), 8'h00);
        ped = 2'b00;
        runWalk(2'b10, 2'b10);

        $display("[TB] road-0 request waits for RG");
        do noServe = 3'($urandom_range(0, 7)); while (noServe == 3'd3);
        applyStimulus(2'b01, 2'b00, noServe);
        stepClk(3);
        checkOutput("ped0_wait", 8'(waitOut), 8'h01);
        ped = 2'b00;
        stepClk($urandom_range(2, 6));
        checkOutput("ped0_no_walk", 8'(walk), 8'h00);
        checkOutput("ped0_idle", 8'(busy), 8'h00);
        phase = 3'd3;
        stepClk(1);
        checkOutput("ped0_walk_rg", 8'(walk), 8'h01);
        checkOutput("ped0_hold", 8'(hold), 8'h01);
        runWalk(2'b01, 2'b01);

        $display("[TB] emergency aborts a walk");
        applyStimulus(2'b10, 2'b00, 3'd0);
        stepClk(4);
        checkOutput("abort_walk_on", 8'(walk), 8'h02);
        ped = 2'b00;
        pulseTick();
        pulseTick();
        checkOutput("abort_walk_2ticks", 8'(walk), 8'h02);
        emg = 2'b01;
        stepClk(2);
        checkOutput("abort_walk_latency", 8'(walk), 8'h02);
        stepClk(1);
        checkOutput("abort_walk_off", 8'(walk), 8'h00);
        checkOutput("abort_force", 8'(forceOut), 8'h01);
        checkOutput("abort_fphase", 8'(forcePhase), 8'h00);
        checkOutput("abort_hold", 8'(hold), 8'h01);
        checkOutput("abort_wait_kept", 8'(waitOut), 8'h02);
        emg = 2'b00;
        stepClk(2);
        checkOutput("abort_force_latency", 8'(forceOut), 8'h01);
        stepClk(1);
        checkOutput("abort_release_force", 8'(forceOut), 8'h00);
        checkOutput("abort_release_wait", 8'(waitOut), 8'h02);
        stepClk(1);
        checkOutput("abort_reserve_walk", 8'(walk), 8'h02);
        runWalk(2'b10, 2'b10);

        $display("[TB] emergency time limit and lockout");
        applyStimulus(2'b00, 2'b10, 3'd3);
        stepClk(3);
        checkOutput("emg1_force", 8'(forceOut), 8'h01);
        checkOutput("emg1_fphase", 8'(forcePhase), 8'h03);
        for (int i = 1; i <= 20; i++) begin
            pulseTick();
            expForce = (i < EMG_MAX);
            checkOutput($sformatf("emg1_force_tick%0d", i), 8'(forceOut), 8'(expForce));
            checkOutput($sformatf("emg1_fphase_tick%0d", i), 8'(forcePhase), expForce ? 8'h03 : 8'h00);
            checkOutput($sformatf("emg1_busy_tick%0d", i), 8'(busy), 8'h01);
        end
        stepClk($urandom_range(3, 8));
        checkOutput("emg1_no_regrant", 8'(forceOut), 8'h00);
        checkOutput("emg1_lock_hold", 8'(hold), 8'h00);
        emg = 2'b00;
        stepClk(3);
        checkOutput("emg1_unlock_idle", 8'(busy), 8'h00);
        emg = 2'b10;
        stepClk(3);
        checkOutput("emg1_regrant", 8'(forceOut), 8'h01);
        checkOutput("emg1_regrant_phase", 8'(forcePhase), 8'h03);
        emg = 2'b00;
        stepClk(3);
        checkOutput("emg1_release", 8'(busy), 8'h00);

        $display("[TB] reset during preemption");
        applyStimulus(2'b01, 2'b00, 3'd0);
        stepClk(3);
        checkOutput("rstmid_wait_set", 8'(waitOut), 8'h01);
        applyStimulus(2'b00, 2'b01, 3'd0);
        stepClk(3);
        checkOutput("rstmid_force_on", 8'(forceOut), 8'h01);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rstmid_force", 8'(forceOut), 8'h00);
        checkOutput("rstmid_hold", 8'(hold), 8'h00);
        checkOutput("rstmid_busy", 8'(busy), 8'h00);
        checkOutput("rstmid_wait", 8'(waitOut), 8'h00);
        emg = 2'b00;
        stepClk(2);
        #3 rst_n = 1'b1;
        stepClk(4);
        checkOutput("rstmid_after_busy", 8'(busy), 8'h00);
        checkOutput("rstmid_after_wait", 8'(waitOut), 8'h00);
        checkOutput("rstmid_after_walk", 8'(walk), 8'h00);

        $display("[TB] emergency arbitration fairness");
        rrModel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pattern = (i < 2) ? 2'b11 : 2'($urandom_range(1, 3));
            winner  = (pattern == 2'b11) ? ~rrModel : pattern[1];
            rrModel = winner;
            applyStimulus(2'b00, pattern, 3'($urandom_range(0, 7)));
            stepClk(3);
            checkOutput($sformatf("arb%0d_force", i), 8'(forceOut), 8'h01);
            checkOutput($sformatf("arb%0d_fphase", i), 8'(forcePhase), winner ? 8'h03 : 8'h00);
            emg = 2'b00;
            stepClk(3);
            checkOutput($sformatf("arb%0d_release", i), 8'(busy), 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] timeout");
    end

endmodule
